// File: rtl/move_controller.sv
// move_controller: sequences the 2048 tile grid. Seeds the board, turns a
// one-hot direction request into a single move pulse for the edge nodes,
// waits for the shift/merge wave to settle, spawns a new tile and flags
// win / game-over.
//
// Handshake: there is no valid/ready back-pressure on this block. dir_req and
// restart are level requests sampled only in the states that accept them
// (IDLE, and OVER for restart); move_ready and preset_ext are one-cycle
// strobes that the grid must take on the rising edge where they are high.
module move_controller #(
    parameter int          GRID_N        = 4,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          WIN_EXP       = 11,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      dir_req,
    input  logic                            restart,
    input  logic [4*GRID_N*GRID_N-1:0]      cell_values,
    output logic [3:0]                      move_ready,
    output logic                            preset_ext,
    output logic [4*GRID_N*GRID_N-1:0]      preset_values,
    output logic                            busy,
    output logic                            game_win,
    output logic                            game_over
);

    // Cell count is a power of two, so index arithmetic wraps naturally.
    localparam int CELLS = GRID_N * GRID_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int BUS_W = 4 * CELLS;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_INIT_WAIT = 4'd1,
        ST_IDLE      = 4'd2,
        ST_MOVE      = 4'd3,
        ST_SETTLE    = 4'd4,
        ST_COMPARE   = 4'd5,
        ST_SCAN      = 4'd6,
        ST_SPAWN     = 4'd7,
        ST_CHECK     = 4'd8,
        ST_OVER      = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [BUS_W-1:0]   snap_q, snap_d;
    logic [BUS_W-1:0]   pv_q, pv_d;
    logic [3:0]         dir_q, dir_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [IDX_W-1:0]   scan_q, scan_d;
    logic [IDX_W-1:0]   pick_q, pick_d;
    logic               win_q, win_d;

    logic               preset_int;
    logic               move_int;
    logic               dir_onehot;
    logic [IDX_W-1:0]   seed_a, seed_b, scan_idx;
    logic               empty_any, pair_any, win_any;
    logic               lfsr_fb;

    // Fibonacci feedback for taps 16,14,13,11.
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign dir_onehot = (dir_req != 4'd0) && ((dir_req & (dir_req - 4'd1)) == 4'd0);

    // Board predicates used by CHECK: any empty cell, any mergeable pair, any winning tile.
    always_comb begin
        empty_any = 1'b0;
        pair_any  = 1'b0;
        win_any   = 1'b0;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                if (cell_values[4*(r*GRID_N+c) +: 4] == 4'd0)
                    empty_any = 1'b1;
                if (cell_values[4*(r*GRID_N+c) +: 4] == 4'(WIN_EXP))
                    win_any = 1'b1;
                if (c < GRID_N-1 && cell_values[4*(r*GRID_N+c) +: 4] != 4'd0 &&
                    cell_values[4*(r*GRID_N+c) +: 4] == cell_values[4*(r*GRID_N+c+1) +: 4])
                    pair_any = 1'b1;
                if (r < GRID_N-1 && cell_values[4*(r*GRID_N+c) +: 4] != 4'd0 &&
                    cell_values[4*(r*GRID_N+c) +: 4] == cell_values[4*((r+1)*GRID_N+c) +: 4])
                    pair_any = 1'b1;
            end
        end
    end

    // Next-state and strobe logic for the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        pv_d       = pv_q;
        dir_d      = dir_q;
        settle_d   = settle_q;
        start_d    = start_q;
        scan_d     = scan_q;
        pick_d     = pick_q;
        win_d      = win_q;
        preset_int = 1'b0;
        move_int   = 1'b0;
        seed_a     = lfsr_q[IDX_W-1:0];
        seed_b     = lfsr_q[2*IDX_W-1:IDX_W];
        scan_idx   = start_q + scan_q;

        case (state_q)
            ST_INIT: begin
                // Two distinct seed tiles; a collision bumps b to the next cell.
                if (seed_b == seed_a)
                    seed_b = seed_a + 1'b1;
                pv_d                       = '0;
                pv_d[4*int'(seed_a) +: 4]  = 4'd1;
                pv_d[4*int'(seed_b) +: 4]  = 4'd1;
                preset_int                 = 1'b1;
                win_d                      = 1'b0;
                state_d                    = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (restart) begin
                    state_d = ST_INIT;
                end else if (dir_onehot) begin
                    snap_d  = cell_values;
                    dir_d   = dir_req;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                move_int = 1'b1;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == CNT_W'(SETTLE_CYCLES-1)) begin
                    settle_d = '0;
                    state_d  = ST_COMPARE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                // An unchanged board means the move was a no-op: no spawn.
                if (cell_values == snap_q) begin
                    state_d = ST_IDLE;
                end else begin
                    start_d = lfsr_q[IDX_W-1:0];
                    scan_d  = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cell_values[4*int'(scan_idx) +: 4] == 4'd0) begin
                    pick_d  = scan_idx;
                    state_d = ST_SPAWN;
                end else if (scan_q == IDX_W'(CELLS-1)) begin
                    state_d = ST_CHECK;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            ST_SPAWN: begin
                pv_d                      = cell_values;
                pv_d[4*int'(pick_q) +: 4] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
                preset_int                = 1'b1;
                state_d                   = ST_CHECK;
            end
            ST_CHECK: begin
                if (win_any)
                    win_d = 1'b1;
                if (!empty_any && !pair_any)
                    state_d = ST_OVER;
                else
                    state_d = ST_IDLE;
            end
            ST_OVER: begin
                if (restart)
                    state_d = ST_INIT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, LFSR and datapath registers; reset lands in INIT with a seeded LFSR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            lfsr_q   <= LFSR_SEED;
            snap_q   <= '0;
            pv_q     <= '0;
            dir_q    <= '0;
            settle_q <= '0;
            start_q  <= '0;
            scan_q   <= '0;
            pick_q   <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
            snap_q   <= snap_d;
            pv_q     <= pv_d;
            dir_q    <= dir_d;
            settle_q <= settle_d;
            start_q  <= start_d;
            scan_q   <= scan_d;
            pick_q   <= pick_d;
            win_q    <= win_d;
        end
    end

    // Reset state is INIT, which would otherwise raise preset_ext/busy; gating
    // with rst keeps every output low while reset is held.
    assign preset_ext    = preset_int & rst;
    assign preset_values = rst ? pv_d : '0;
    assign move_ready    = move_int ? dir_q : 4'd0;
    assign busy          = rst & (state_q != ST_IDLE) & (state_q != ST_OVER);
    assign game_win      = win_q;
    assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a behavioural grid that loads
// preset_values on preset_ext and otherwise takes board writes from the tests.
module tb_move_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  dir_req = 4'd0;
    logic        restart = 1'b0;
    logic [63:0] grid_q = 64'd0;
    logic [3:0]  move_ready;
    logic        preset_ext;
    logic [63:0] preset_values;
    logic        busy;
    logic        game_win;
    logic        game_over;

    logic        wr_en = 1'b0;
    logic [63:0] wr_val = 64'd0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] SEED_BOARD = 64'h0100_0000_0000_0010;

    // Clock
    always #5 clk = ~clk;

    move_controller dut (
        .clk           (clk),
        .rst           (rst),
        .dir_req       (dir_req),
        .restart       (restart),
        .cell_values   (grid_q),
        .move_ready    (move_ready),
        .preset_ext    (preset_ext),
        .preset_values (preset_values),
        .busy          (busy),
        .game_win      (game_win),
        .game_over     (game_over)
    );

    // Grid model: preset wins over a test-driven board write.
    always @(posedge clk) begin
        if (preset_ext)
            grid_q <= preset_values;
        else if (wr_en)
            grid_q <= wr_val;
    end

    function automatic int count_val(input logic [63:0] b, input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (b[4*i +: 4] == v) n++;
        return n;
    endfunction

    // Returns 1 when p equals b except for one previously empty cell now holding 1 or 2.
    function automatic logic one_spawn(input logic [63:0] b, input logic [63:0] p);
        int diffs = 0;
        logic ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (p[4*i +: 4] != b[4*i +: 4]) begin
                diffs++;
                if (b[4*i +: 4] != 4'd0) ok = 1'b0;
                if (p[4*i +: 4] != 4'd1 && p[4*i +: 4] != 4'd2) ok = 1'b0;
            end
        end
        return ok && (diffs == 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, preset_ext, move_ready, game_over, game_win} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {busy, preset_ext, move_ready, game_over, game_win});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (preset_ext !== 1'b1 || preset_values !== SEED_BOARD || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_preset: ext=%b vals=%h busy=%b expected ext=1 vals=%h busy=1",
                     preset_ext, preset_values, busy, SEED_BOARD);
        end
        @(negedge clk);
        n_tests++;
        if (preset_ext !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_wait: ext=%b busy=%b expected ext=0 busy=1", preset_ext, busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || grid_q !== SEED_BOARD) begin
            n_fail++;
            $display("FAIL idle_after_init: busy=%b grid=%h expected busy=0 grid=%h", busy, grid_q, SEED_BOARD);
        end
    endtask

    // Changing move; restart pulsed during SETTLE must be ignored.
    task automatic test_move();
        logic [63:0] bmove = 64'h0110_0000_0000_0000;
        logic found = 1'b0;
        dir_req = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (move_ready !== 4'b0100 || preset_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL move_pulse: ready=%b ext=%b expected ready=0100 ext=0", move_ready, preset_ext);
        end
        dir_req = 4'd0;
        restart = 1'b1;
        wr_val  = bmove;
        wr_en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (i == 3) restart = 1'b0;
            n_tests++;
            if (move_ready !== 4'd0 || preset_ext !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL settle_quiet[%0d]: ready=%b ext=%b busy=%b expected 0,0,1", i, move_ready, preset_ext, busy);
            end
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (preset_ext === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL spawn_seen: got no preset within 30 cycles, expected one");
        end
        n_tests++;
        if (one_spawn(bmove, preset_values) !== 1'b1) begin
            n_fail++;
            $display("FAIL spawn_tile: got %h expected %h plus one 1/2 tile in an empty cell", preset_values, bmove);
        end
        @(negedge clk);
        n_tests++;
        if (preset_ext !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL spawn_single: ext=%b busy=%b expected ext=0 busy=1", preset_ext, busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL move_done: busy=%b over=%b expected 0,0", busy, game_over);
        end
    endtask

    // Invalid request is ignored; a no-op move returns to IDLE without a spawn.
    task automatic test_invalid();
        dir_req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (move_ready !== 4'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_dir[%0d]: ready=%b busy=%b expected 0,0", i, move_ready, busy);
            end
        end
        dir_req = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (move_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL noop_pulse: ready=%b expected 0001", move_ready);
        end
        dir_req = 4'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if (preset_ext !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL noop_busy[%0d]: ext=%b busy=%b expected 0,1", i, preset_ext, busy);
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || preset_ext !== 1'b0) begin
            n_fail++;
            $display("FAIL noop_idle: busy=%b ext=%b expected 0,0", busy, preset_ext);
        end
    endtask

    // Full board without merges: 16-cycle scan, no spawn, OVER, then restart.
    task automatic test_game_over();
        logic [63:0] full = 64'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                full[4*(r*4+c) +: 4] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
        dir_req = 4'b1000;
        @(negedge clk);
        n_tests++;
        if (move_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL over_pulse: ready=%b expected 1000", move_ready);
        end
        dir_req = 4'd0;
        wr_val  = full;
        wr_en   = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            n_tests++;
            if (preset_ext !== 1'b0 || game_over !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL full_scan[%0d]: ext=%b over=%b busy=%b expected 0,0,1", i, preset_ext, game_over, busy);
            end
        end
        @(negedge clk);
        n_tests++;
        if (game_over !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL over_entry: over=%b busy=%b expected 1,0", game_over, busy);
        end
        dir_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (game_over !== 1'b1 || move_ready !== 4'd0) begin
                n_fail++;
                $display("FAIL over_hold[%0d]: over=%b ready=%b expected 1,0000", i, game_over, move_ready);
            end
        end
        dir_req = 4'd0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_tests++;
        if (game_over !== 1'b0 || preset_ext !== 1'b1 || count_val(preset_values, 4'd1) != 2 ||
            count_val(preset_values, 4'd0) != 14) begin
            n_fail++;
            $display("FAIL over_restart: over=%b ext=%b vals=%h expected 0,1,two cells of 1", game_over, preset_ext, preset_values);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_idle: busy=%b expected 0", busy);
        end
    endtask

    // Tile of 11 after a move sets game_win; it survives a no-op move and clears on restart.
    task automatic test_win();
        logic [63:0] bwin = 64'h0000_0000_0000_030B;
        logic found = 1'b0;
        n_tests++;
        if (game_win !== 1'b0) begin
            n_fail++;
            $display("FAIL win_start: win=%b expected 0", game_win);
        end
        dir_req = 4'b0010;
        @(negedge clk);
        dir_req = 4'd0;
        wr_val  = bwin;
        wr_en   = 1'b1;
        repeat (8) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (preset_ext === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (found !== 1'b1 || game_win !== 1'b0 || one_spawn(bwin, preset_values) !== 1'b1) begin
            n_fail++;
            $display("FAIL win_spawn: found=%b win=%b vals=%h expected 1,0,one tile added to %h", found, game_win, preset_values, bwin);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (game_win !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL win_set: win=%b busy=%b expected 1,0", game_win, busy);
        end
        dir_req = 4'b0001;
        @(negedge clk);
        dir_req = 4'd0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (game_win !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL win_sticky: win=%b busy=%b expected 1,0", game_win, busy);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (game_win !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL win_clear: win=%b busy=%b expected 0,0", game_win, busy);
        end
    endtask

    // Reset asserted in SETTLE clears outputs at once and replays the seeded INIT.
    task automatic test_reset_mid();
        dir_req = 4'b0100;
        @(negedge clk);
        dir_req = 4'd0;
        wr_val  = 64'h0000_0000_0000_0021;
        wr_en   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, preset_ext, move_ready, game_over, game_win} !== 8'd0 || preset_values !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: flags=%b vals=%h expected all 0", {busy, preset_ext, move_ready, game_over, game_win}, preset_values);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (preset_ext !== 1'b1 || preset_values !== SEED_BOARD) begin
            n_fail++;
            $display("FAIL mid_reinit: ext=%b vals=%h expected 1,%h", preset_ext, preset_values, SEED_BOARD);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || grid_q !== SEED_BOARD) begin
            n_fail++;
            $display("FAIL mid_idle: busy=%b grid=%h expected 0,%h", busy, grid_q, SEED_BOARD);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_invalid();
        test_game_over();
        test_win();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Sequences the 2048 tile grid, a GRID_N x GRID_N array of node cells.
- Seeds the initial board through the nodes' preset path.
- Converts one-hot direction requests into a single ready pulse that starts the edge nodes' shift/merge wave, then waits for the grid to settle.
- Spawns a new tile by re-presetting the grid, and flags win and game-over.

Parameters:
- GRID_N, 4: grid side length; cell count = GRID_N*GRID_N = 16.
- SETTLE_CYCLES, 8: cycles waited after the move pulse before the grid is sampled.
- WIN_EXP, 11: tile exponent that sets game_win (2^11 = 2048).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dir_req  in  4  direction request. Bit 0 up, 1 right, 2 down, 3 left. Sampled only in IDLE.
- restart  in  1  new-game request. Accepted in IDLE and OVER only.
- cell_values  in  64  current exponent of every cell, 4 bits per cell. Cell i is bits [4i+3:4i]; 0 = empty.
- move_ready  out  4  one-cycle one-hot pulse to the grid's ready_from, same bit mapping as dir_req.
- preset_ext  out  1  one-cycle load strobe to all nodes.
- preset_values  out  64  per-cell preset values, valid while preset_ext = 1.
- busy  out  1  high in every state except IDLE and OVER.
- game_win  out  1  sticky win flag.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (rst = 0, asynchronous):
  - all outputs 0, state INIT, settle counter 0, scan counter 0, LFSR = LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state.
- States: INIT, INIT_WAIT, IDLE, MOVE, SETTLE, COMPARE, SCAN, SPAWN, CHECK, OVER.
- INIT (1 cycle):
  - a = lfsr[3:0]; b = lfsr[7:4], or (a+1) mod 16 if b == a.
  - preset_values has 4'd1 at cells a and b, 0 elsewhere; preset_ext = 1; game_win cleared.
  - Next state INIT_WAIT.
- INIT_WAIT (1 cycle): next state IDLE.
- IDLE:
  - dir_req exactly one-hot: snapshot cell_values, go to MOVE.
  - dir_req zero or more than one bit set: ignored, stay in IDLE.
  - restart takes priority over dir_req: go to INIT.
- MOVE (exactly 1 cycle):
  - move_ready = captured direction; preset_ext = 0.
  - Next state SETTLE with counter = 0.
- SETTLE:
  - Counter increments each cycle.
  - Exits to COMPARE when counter == SETTLE_CYCLES-1, i.e. after exactly SETTLE_CYCLES cycles.
- COMPARE (1 cycle):
  - cell_values == snapshot: the move had no effect, go to IDLE with no spawn.
  - Otherwise: latch start = lfsr[3:0], scan counter = 0, go to SCAN.
- SCAN (one cell per cycle):
  - Examines cell (start + k) mod 16.
  - First empty cell found: latch index, go to SPAWN.
  - All 16 cells occupied (k reaches 15 with no hit): go to CHECK with no spawn.
  - Worst case 16 cycles.
- SPAWN (1 cycle):
  - preset_values = cell_values with the chosen cell set to 4'd2 if lfsr[7:4] == 0, else 4'd1.
  - preset_ext = 1. Next state CHECK.
- CHECK (1 cycle, on the post-preset cell_values):
  - Any cell == WIN_EXP: set game_win (stays set until INIT or reset).
  - No empty cell and no horizontally or vertically adjacent equal non-zero pair: go to OVER.
  - Otherwise go to IDLE.
- OVER:
  - game_over = 1; dir_req ignored.
  - restart: go to INIT; game_over drops on the same edge.
- preset_values holds its last driven value outside preset cycles; it is don't-care when preset_ext = 0.
- move_ready and preset_ext are never high in the same cycle. Each pulse lasts exactly one cycle.
- A restart during busy states is ignored. A reset mid-operation aborts immediately to INIT.

Test Plan:
- Reset, then release → preset_ext high for 1 cycle at INIT with exactly two distinct cells = 1; busy = 0 two cycles later (in IDLE).
- Board changes after dir_req = 4'b0100 → move_ready = 4'b0100 for exactly 1 cycle, no preset during the 8 SETTLE cycles, then one preset_ext pulse adding exactly one tile of value 1 or 2 in a previously empty cell.
- dir_req = 4'b0101, or a move that leaves cell_values unchanged → no move_ready pulse for the invalid request; no preset_ext pulse for the no-op move; returns to IDLE.
- Full board, no equal neighbours, after a changing move → SCAN takes 16 cycles, no spawn, game_over = 1; restart → INIT and game_over = 0.
- A cell reaches 11 after spawn → game_win = 1 and stays set through subsequent moves until restart.
- Assert rst mid-SETTLE → all outputs 0 asynchronously; after release the INIT preset sequence repeats.
